// File: rtl/kmkz_writeback.sv
// Writeback stage: registers the X-stage instruction, selects/aligns its result, one RF write per instruction.
// Zero added latency from W register to RF write; stalls the pipeline (w_stall_req_o) while load data is pending.
module kmkz_writeback #(
  parameter int unsigned G_INSTRET_WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       x_stall_i,
  input  logic                       x_valid_i,
  input  logic [4:0]                 x_rd_i,
  input  logic                       x_rd_write_i,
  input  logic [1:0]                 x_rd_source_i,
  input  logic [31:0]                x_rd_value_i,
  input  logic [2:0]                 x_load_fun_i,
  input  logic [1:0]                 x_dm_addr_i,
  input  logic [31:0]                sh_rd_value_i,
  input  logic [31:0]                mul_rd_value_i,
  input  logic                       dm_load_done_i,
  input  logic [31:0]                dm_data_l_i,
  output logic                       w_stall_req_o,
  output logic                       rf_rd_write_o,
  output logic [4:0]                 rf_rd_o,
  output logic [31:0]                rf_rd_value_o,
  output logic [G_INSTRET_WIDTH-1:0] w_instret_o
);

  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_WAIT_LOAD, S_RETIRED} state_t;

  localparam logic [1:0] SRC_ALU   = 2'b00;
  localparam logic [1:0] SRC_SHIFT = 2'b01;
  localparam logic [1:0] SRC_LOAD  = 2'b10;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [4:0]                 r_rd;
  logic                       r_rd_write;
  logic [1:0]                 r_src;
  logic [31:0]                r_alu;
  logic [2:0]                 r_fun;
  logic [1:0]                 r_addr;
  logic [G_INSTRET_WIDTH-1:0] r_instret;

  logic        w_is_load;
  logic        w_stall;
  logic        w_retire;
  logic        w_wreg_load;
  logic        w_rf_write;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [31:0] w_result;

  assign w_is_load   = (r_src == SRC_LOAD);
  assign w_wreg_load = !x_stall_i && !w_stall;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stall is combinational so a load whose data arrives in its first W cycle never stalls.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        w_stall     = w_is_load && !dm_load_done_i;
        w_retire    = !w_is_load || dm_load_done_i;
        w_state_nxt = w_retire ? S_RETIRED : S_WAIT_LOAD;
      end
      S_WAIT_LOAD: begin
        w_stall     = !dm_load_done_i;
        w_retire    = dm_load_done_i;
        w_state_nxt = dm_load_done_i ? S_RETIRED : S_WAIT_LOAD;
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
    if (w_wreg_load) begin
      w_state_nxt = x_valid_i ? S_ACTIVE : S_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd       <= 5'd0;
      r_rd_write <= 1'b0;
      r_src      <= 2'd0;
      r_alu      <= 32'd0;
      r_fun      <= 3'd0;
      r_addr     <= 2'd0;
    end else if (w_wreg_load) begin
      r_rd       <= x_rd_i;
      r_rd_write <= x_rd_write_i;
      r_src      <= x_rd_source_i;
      r_alu      <= x_rd_value_i;
      r_fun      <= x_load_fun_i;
      r_addr     <= x_dm_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  // Undefined funct3 encodings fall through to a whole-word load.
  always_comb begin
    w_byte = dm_data_l_i[7:0];
    case (r_addr)
      2'd1:    w_byte = dm_data_l_i[15:8];
      2'd2:    w_byte = dm_data_l_i[23:16];
      2'd3:    w_byte = dm_data_l_i[31:24];
      default: w_byte = dm_data_l_i[7:0];
    endcase
    w_half = r_addr[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
    case (r_fun)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = dm_data_l_i;
    endcase
  end

  always_comb begin
    case (r_src)
      SRC_ALU:   w_result = r_alu;
      SRC_SHIFT: w_result = sh_rd_value_i;
      SRC_LOAD:  w_result = w_load_val;
      default:   w_result = mul_rd_value_i;
    endcase
  end

  assign w_rf_write = w_retire && r_rd_write && (r_rd != 5'd0);

  assign w_stall_req_o = w_stall;
  assign rf_rd_write_o = w_rf_write;
  assign rf_rd_o       = r_rd;
  assign rf_rd_value_o = w_rf_write ? w_result : 32'd0;
  assign w_instret_o   = r_instret;

endmodule
